// File: rtl/pwm_channel_decoder.sv
// Multi-channel RC PWM demodulator: width, hysteresis level, valid strobe.
// Optional signal-loss failsafe compiled in with PWM_DECODER_FAILSAFE_EN.
module pwm_channel_decoder #(
  parameter int CHANNELS           = 8,
  parameter int COUNTER_WIDTH      = 12,
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1800,
  parameter int LOW_COUNTER_VALUE  = 1200,
  parameter int TIMEOUT_VALUE      = 25000,
  parameter int FAILSAFE_LEVEL     = 0
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  input  logic [CHANNELS-1:0]               pwm_i,
  output logic [CHANNELS*COUNTER_WIDTH-1:0] width_o,
  output logic [CHANNELS-1:0]               level_o,
  output logic [CHANNELS-1:0]               valid_o,
  output logic [CHANNELS-1:0]               failsafe_o
);

  localparam int CW = COUNTER_WIDTH;

  localparam logic [0:0] ST_WAIT_RISE = 1'b0;
  localparam logic [0:0] ST_MEASURE   = 1'b1;

  localparam logic [CW-1:0] L_MAX  = CW'(MAX_COUNTER_VALUE);
  localparam logic [CW-1:0] L_HIGH = CW'(HIGH_COUNTER_VALUE);
  localparam logic [CW-1:0] L_LOW  = CW'(LOW_COUNTER_VALUE);

  if (!(LOW_COUNTER_VALUE < HIGH_COUNTER_VALUE &&
        HIGH_COUNTER_VALUE <= MAX_COUNTER_VALUE &&
        MAX_COUNTER_VALUE < (1 << CW)) ||
      TIMEOUT_VALUE < 1 ||
      FAILSAFE_LEVEL < 0 || FAILSAFE_LEVEL > 1) begin : g_bad_cfg
    $error("pwm_channel_decoder: illegal parameter set");
  end

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_prev;
  logic [CHANNELS-1:0] r_state;
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_valid;
  logic [CW-1:0]       r_count [CHANNELS];
  logic [CW-1:0]       r_width [CHANNELS];

  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_done;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_done = r_state & ~r_sync2 & {CHANNELS{enable_i}};

`ifdef PWM_DECODER_FAILSAFE_EN
  localparam int TW = $clog2(TIMEOUT_VALUE + 1);
  localparam logic [TW-1:0] L_TO    = TW'(TIMEOUT_VALUE);
  localparam logic [TW-1:0] L_TO_M1 = TW'(TIMEOUT_VALUE - 1);
  localparam logic          L_FS_LV = (FAILSAFE_LEVEL != 0);

  logic [TW-1:0]       r_to [CHANNELS];
  logic [CHANNELS-1:0] r_fs;

  assign failsafe_o = r_fs;
`else
  assign failsafe_o = '0;
`endif

  // Sync regs reset high so a line already high at release is no edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_state <= {CHANNELS{ST_WAIT_RISE}};
      r_level <= '0;
      r_valid <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_count[c] <= '0;
        r_width[c] <= '0;
`ifdef PWM_DECODER_FAILSAFE_EN
        r_to[c]    <= '0;
`endif
      end
`ifdef PWM_DECODER_FAILSAFE_EN
      r_fs <= '0;
`endif
    end else begin
      r_sync1 <= pwm_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= w_done;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!enable_i) begin
          r_state[c] <= ST_WAIT_RISE;
          r_count[c] <= '0;
        end else if (r_state[c] == ST_WAIT_RISE) begin
          if (w_rise[c]) begin
            r_state[c] <= ST_MEASURE;
            r_count[c] <= CW'(1);
          end
        end else if (r_sync2[c]) begin
          if (r_count[c] != L_MAX)
            r_count[c] <= r_count[c] + 1'b1;
        end else begin
          r_state[c] <= ST_WAIT_RISE;
          r_width[c] <= r_count[c];
          if (r_count[c] >= L_HIGH)
            r_level[c] <= 1'b1;
          else if (r_count[c] <= L_LOW)
            r_level[c] <= 1'b0;
        end
`ifdef PWM_DECODER_FAILSAFE_EN
        // Timeout freezes while disabled; a fresh strobe always wins.
        if (w_done[c]) begin
          r_to[c] <= '0;
          r_fs[c] <= 1'b0;
        end else if (enable_i && r_to[c] != L_TO) begin
          r_to[c] <= r_to[c] + 1'b1;
          if (r_to[c] == L_TO_M1) begin
            r_fs[c]    <= 1'b1;
            r_level[c] <= L_FS_LV;
          end
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_width
    assign width_o[g*CW +: CW] = r_width[g];
  end

  assign level_o = r_level;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_pwm_channel_decoder.sv
// Bench for pwm_channel_decoder: directed table, corner sequences and
// random traffic against a pulse-run reference model.
module tb_pwm_channel_decoder;

  localparam int CH   = 8;
  localparam int CW   = 12;
  localparam int MAXV = 2000;
  localparam int HIV  = 1800;
  localparam int LOV  = 1200;
  localparam int TO   = 25000;
  localparam int FSL  = 0;
  localparam int NE   = 1 << 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [CH-1:0]     pwm;
  logic [CH*CW-1:0]  width_o;
  logic [CH-1:0]     level_o;
  logic [CH-1:0]     valid_o;
  logic [CH-1:0]     failsafe_o;

  pwm_channel_decoder #(
    .CHANNELS           (CH),
    .COUNTER_WIDTH      (CW),
    .MAX_COUNTER_VALUE  (MAXV),
    .HIGH_COUNTER_VALUE (HIV),
    .LOW_COUNTER_VALUE  (LOV),
    .TIMEOUT_VALUE      (TO),
    .FAILSAFE_LEVEL     (FSL)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .enable_i   (en),
    .pwm_i      (pwm),
    .width_o    (width_o),
    .level_o    (level_o),
    .valid_o    (valid_o),
    .failsafe_o (failsafe_o)
  );

  always #5 clk = ~clk;

  // History of effective pin samples, enable and reset per clock edge.
  logic [CH-1:0] h_eff [NE];
  bit            h_en  [NE];
  bit            h_rst [NE];
  int            e = -1;

  int m_w    [CH];
  bit m_lvl  [CH];
  bit m_val  [CH];
  bit m_fs   [CH];
  int m_idle [CH];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  // A pulse is published two edges after its first low sample if the
  // run of high samples began after a low and was never interrupted by
  // reset or disable from its acceptance edge onward.
  task automatic model_edge();
    int  j;
    int  w;
    bit  ok;
    if (h_rst[e]) begin
      for (int t = e - 2; t <= e; t++)
        if (t >= 0) h_eff[t] = '1;
      for (int c = 0; c < CH; c++) begin
        m_w[c] = 0; m_lvl[c] = 0; m_val[c] = 0;
        m_fs[c] = 0; m_idle[c] = 0;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      m_val[c] = 0;
      ok = 0;
      if (h_en[e] && e >= 3 && !h_eff[e-2][c] && h_eff[e-3][c]) begin
        j = e - 3;
        while (j > 0 && h_eff[j-1][c]) j--;
        ok = (j > 0);
        for (int t = j + 2; t <= e; t++)
          if (!h_en[t] || h_rst[t]) ok = 0;
      end
      if (ok) begin
        w = e - 2 - j;
        if (w > MAXV) w = MAXV;
        m_w[c]   = w;
        m_val[c] = 1;
        if (w >= HIV) m_lvl[c] = 1;
        else if (w <= LOV) m_lvl[c] = 0;
      end
`ifdef PWM_DECODER_FAILSAFE_EN
      if (ok) begin
        m_idle[c] = 0;
        m_fs[c]   = 0;
      end else if (h_en[e] && m_idle[c] < TO) begin
        m_idle[c]++;
        if (m_idle[c] == TO) begin
          m_fs[c]  = 1;
          m_lvl[c] = (FSL != 0);
        end
      end
`endif
    end
  endtask

  task automatic compare_outputs();
    logic [CH*CW-1:0] xw;
    logic [CH-1:0]    xl, xv, xf;
    for (int c = 0; c < CH; c++) begin
      xw[c*CW +: CW] = CW'(m_w[c]);
      xl[c] = m_lvl[c];
      xv[c] = m_val[c];
      xf[c] = m_fs[c];
    end
    checks++;
    if ({width_o, level_o, valid_o, failsafe_o} !== {xw, xl, xv, xf}) begin
      errors++;
      $display("FAIL cycle_%0d: width %h lvl %b val %b fs %b, want width %h lvl %b val %b fs %b",
               e, width_o, level_o, valid_o, failsafe_o, xw, xl, xv, xf);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    h_eff[e] = rst ? '1 : pwm;
    h_en[e]  = en;
    h_rst[e] = rst;
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int c, input int n, output int w,
                       output bit l, output int ns, output int at);
    pwm[c] = 1'b1;
    run(n);
    pwm[c] = 1'b0;
    w = -1; l = 0; ns = 0; at = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (valid_o[c]) begin
        ns++;
        at = i;
        w  = int'(width_o[c*CW +: CW]);
        l  = level_o[c];
      end
    end
  endtask

  typedef struct {
    int ch;
    int hi;
    int w;
    bit lvl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int w, ns, at, nv, n;
    bit l;
    int ws[$];
    int rem [CH];
    int en_hold;

    tbl[0]  = '{0, 1500, 1500, 0};
    tbl[1]  = '{1, 1900, 1900, 1};
    tbl[2]  = '{1, 1500, 1500, 1};
    tbl[3]  = '{1, 1100, 1100, 0};
    tbl[4]  = '{2, 3000, 2000, 1};
    tbl[5]  = '{3, 1,    1,    0};
    tbl[6]  = '{4, 1200, 1200, 0};
    tbl[7]  = '{4, 1800, 1800, 1};
    tbl[8]  = '{4, 1201, 1201, 1};
    tbl[9]  = '{4, 1200, 1200, 0};
    tbl[10] = '{5, 2000, 2000, 1};
    tbl[11] = '{5, 1799, 1799, 1};

    rst = 1'b1; en = 1'b1; pwm = '0;
    run(3);
    chk("reset_width", longint'(width_o == '0), 1);
    chk("reset_level", longint'(level_o), 0);
    chk("reset_valid", longint'(valid_o), 0);
    chk("reset_failsafe", longint'(failsafe_o), 0);
    rst = 1'b0;
    run(5);

    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].ch, tbl[i].hi, w, l, ns, at);
      chk($sformatf("tbl%0d_strobes", i), ns, 1);
      chk($sformatf("tbl%0d_latency", i), at, 3);
      chk($sformatf("tbl%0d_width", i), w, tbl[i].w);
      chk($sformatf("tbl%0d_level", i), l, tbl[i].lvl);
    end

    // Back-to-back pulses with a single low sample between them.
    for (int i = 0; i < 20; i++) begin
      pwm[7] = (i < 5) || (i >= 6 && i < 13);
      step();
      if (valid_o[7]) ws.push_back(int'(width_o[7*CW +: CW]));
    end
    pwm[7] = 1'b0;
    chk("b2b_count", ws.size(), 2);
    if (ws.size() == 2) begin
      chk("b2b_first", ws[0], 5);
      chk("b2b_second", ws[1], 7);
    end

    // Reset in the middle of a pulse at count 800.
    pwm[0] = 1'b1;
    run(802);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_width", longint'(width_o == '0), 1);
    chk("midrst_level", longint'(level_o), 0);
    chk("midrst_valid", longint'(valid_o), 0);
    run(200);
    pwm[0] = 1'b0;
    nv = 0;
    repeat (10) begin step(); nv += int'(valid_o[0]); end
    chk("midrst_no_strobe", nv, 0);

    // Line high through reset release.
    pwm[3] = 1'b1;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(500);
    pwm[3] = 1'b0;
    nv = 0;
    repeat (10) begin step(); nv += int'(valid_o[3]); end
    chk("hirst_no_strobe", nv, 0);
    pulse(3, 1300, w, l, ns, at);
    chk("hirst_next_strobes", ns, 1);
    chk("hirst_next_width", w, 1300);

    pulse(6, 1900, w, l, ns, at);
    chk("fs_pre_level", l, 1);
`ifdef PWM_DECODER_FAILSAFE_EN
    n = 0;
    while (!failsafe_o[6] && n < TO + 10) begin step(); n++; end
    chk("fs_latency", n, TO - 3);
    chk("fs_level", longint'(level_o[6]), FSL);
    pulse(6, 1900, w, l, ns, at);
    chk("fs_recover_width", w, 1900);
    chk("fs_recover_level", l, 1);
    chk("fs_recover_flag", longint'(failsafe_o[6]), 0);
`else
    run(300);
    chk("nofs_flag", longint'(failsafe_o[6]), 0);
    chk("nofs_level", longint'(level_o[6]), 1);
`endif

    en_hold = 0;
    for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 300);
    repeat (20000) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          pwm[c] = ~pwm[c];
          if ($urandom_range(0, 3) == 0) rem[c] = $urandom_range(1, 4);
          else rem[c] = $urandom_range(5, 2300);
        end else begin
          rem[c]--;
        end
      end
      if (en_hold > 0) en_hold--;
      else if ($urandom_range(0, 2999) == 0) en_hold = $urandom_range(1, 40);
      en  = (en_hold == 0);
      rst = ($urandom_range(0, 9999) == 0);
      step();
    end
    rst = 1'b0;
    en  = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
